// File: rtl/led_trail_fader.sv
// Trail fader for a 16-LED scroller: lit LEDs decay through 16 brightness
// levels after switching off, rendered with a free-running 15-step PWM.
module led_trail_fader #(
  parameter logic [23:0] DECAY_DIV = 24'd2_000_000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] led_in,
  input  logic        fade_en,
  output logic [15:0] led_out,
  output logic        fading
);

  logic [15:0]       led_q;
  logic [15:0][3:0]  lvl;
  logic [15:0][3:0]  lvl_nxt;
  logic [23:0]       div_cnt;
  logic [3:0]        pwm_cnt;
  logic              decay_tick;
  logic [15:0]       out_nxt;
  logic              fading_nxt;

  assign decay_tick = (div_cnt == DECAY_DIV - 24'd1);

  // Reload beats clear, clear beats decay; decay saturates at zero.
  always_comb begin
    lvl_nxt    = lvl;
    out_nxt    = '0;
    fading_nxt = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (led_q[i])
        lvl_nxt[i] = 4'd15;
      else if (!fade_en)
        lvl_nxt[i] = '0;
      else if (decay_tick && (lvl[i] != '0))
        lvl_nxt[i] = lvl[i] - 4'd1;
      out_nxt[i] = (lvl[i] > pwm_cnt);
      if (!led_q[i] && (lvl[i] != '0) && (lvl[i] != 4'd15))
        fading_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_q   <= '0;
      lvl     <= '0;
      div_cnt <= '0;
      pwm_cnt <= '0;
      led_out <= '0;
      fading  <= 1'b0;
    end else begin
      led_q   <= led_in;
      lvl     <= lvl_nxt;
      div_cnt <= decay_tick ? '0 : div_cnt + 24'd1;
      pwm_cnt <= (pwm_cnt == 4'd14) ? '0 : pwm_cnt + 4'd1;
      led_out <= out_nxt;
      fading  <= fading_nxt;
    end
  end

endmodule

// File: tb/tb_led_trail_fader.sv
// Bench for led_trail_fader: directed scenarios plus random traffic, checked
// cycle by cycle against a cycle-count based brightness model.
module tb_led_trail_fader;

  localparam logic [23:0] DIV = 24'd4;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] led_in = '0;
  logic        fade_en = 1'b0;
  logic [15:0] led_out;
  logic        fading;

  led_trail_fader #(.DECAY_DIV(DIV)) dut (
    .clk(clk), .resetn(resetn), .led_in(led_in), .fade_en(fade_en),
    .led_out(led_out), .fading(fading)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: brightness per LED, sampled input, expected outputs, edges since release.
  int          m_lvl [16];
  logic [15:0] m_q;
  logic [15:0] m_out;
  logic        m_fad;
  int          m_edges;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q = '0; m_out = '0; m_fad = 1'b0; m_edges = 0;
    for (int i = 0; i < 16; i++) m_lvl[i] = 0;
  endtask

  task automatic model_edge();
    int pwm;
    bit tick;
    logic [15:0] nout;
    logic nfad;
    pwm  = m_edges % 15;
    tick = (m_edges % D) == D - 1;
    nout = '0;
    nfad = 1'b0;
    for (int i = 0; i < 16; i++) begin
      nout[i] = (m_lvl[i] > pwm);
      if (!m_q[i] && m_lvl[i] > 0 && m_lvl[i] < 15) nfad = 1'b1;
    end
    for (int i = 0; i < 16; i++) begin
      if (m_q[i]) m_lvl[i] = 15;
      else if (!fade_en) m_lvl[i] = 0;
      else if (tick && m_lvl[i] > 0) m_lvl[i] = m_lvl[i] - 1;
    end
    m_out = nout; m_fad = nfad; m_q = led_in; m_edges++;
  endtask

  task automatic step();
    @(posedge clk);
    if (resetn) model_edge(); else model_reset();
    #1;
    chk("led_out", led_out, m_out);
    chk("fading", {15'd0, fading}, {15'd0, m_fad});
  endtask

  initial begin
    int cnt, prev;
    bit found;
    logic [15:0] pat;

    model_reset();
    repeat (3) step();
    chk("reset_led_out", led_out, 16'h0000);
    resetn = 1'b1;

    // Single LED steady on
    led_in = 16'h0001; fade_en = 1'b1;
    repeat (3) step();
    for (int k = 0; k < 20; k++) begin
      step();
      chk("steady_on", led_out, 16'h0001);
      chk("steady_fading", {15'd0, fading}, 16'h0000);
    end

    // Full decay: PWM duty per 15-cycle window never increases
    led_in = 16'h0000;
    prev = 16;
    for (int w = 0; w < 6; w++) begin
      cnt = 0;
      for (int k = 0; k < 15; k++) begin
        step();
        if (led_out[0]) cnt++;
      end
      checks++;
      assert (cnt <= prev) else begin
        errors++;
        $error("FAIL decay_monotonic: observed %0d expected <= %0d", cnt, prev);
      end
      prev = cnt;
    end
    chk("decay_done_out", led_out, 16'h0000);
    chk("decay_done_fading", {15'd0, fading}, 16'h0000);

    // fade_en dropped mid-fade at level 9
    led_in = 16'h0008;
    repeat (4) step();
    led_in = 16'h0000;
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      step();
      if (m_lvl[3] == 9) found = 1;
    end
    checks++;
    assert (found) else begin errors++; $error("FAIL lvl9_timeout: observed 0 expected 1"); end
    fade_en = 1'b0;
    repeat (2) step();
    chk("clear_led3", {15'd0, led_out[3]}, 16'h0000);
    chk("clear_fading", {15'd0, fading}, 16'h0000);
    fade_en = 1'b1;
    repeat (3) step();

    // Reload coinciding with a decay tick at level 7
    led_in = 16'h0020;
    repeat (3) step();
    led_in = 16'h0000;
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      step();
      if (m_lvl[5] == 7 && (m_edges % D) == D - 2) found = 1;
    end
    checks++;
    assert (found) else begin errors++; $error("FAIL lvl7_timeout: observed 0 expected 1"); end
    led_in = 16'h0020;
    step();
    led_in = 16'h0000;
    repeat (2) step();
    chk("reload_led5", {15'd0, led_out[5]}, 16'h0001);
    chk("reload_not14", {15'd0, fading}, 16'h0000);
    repeat (70) step();

    // Rotating dark bit
    pat = 16'hfffe;
    for (int r = 0; r < 32; r++) begin
      led_in = pat;
      repeat (8) step();
      pat = {pat[14:0], pat[15]};
    end

    // Random traffic with occasional direct-mode intervals
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(7) == 0) led_in = 16'($urandom) & 16'($urandom);
      if ($urandom_range(39) == 0) fade_en = ~fade_en;
      step();
    end
    fade_en = 1'b1;

    // Asynchronous reset during a fade
    led_in = 16'hffff;
    repeat (4) step();
    led_in = 16'h0000;
    repeat (10) step();
    @(posedge clk);
    model_edge();
    #3;
    resetn = 1'b0;
    #1;
    chk("async_reset_out", led_out, 16'h0000);
    chk("async_reset_fading", {15'd0, fading}, 16'h0000);
    model_reset();
    repeat (3) step();
    resetn = 1'b1;
    repeat (20) step();
    chk("post_reset_dark", led_out, 16'h0000);
    led_in = 16'h8001;
    repeat (80) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_trail_fader.md
LED_TRAIL_FADER -- requirements
Module: led_trail_fader

Interface
REQ-001 Parameter DECAY_DIV, default 24'd2_000_000, clk cycles between successive brightness decay steps (legal range 1..2^24-1).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset; assertion clears all state immediately, deassertion is synchronised to clk by the integrator.
REQ-004 led_in  input  16  on/off LED pattern from the scroller stage; bit=1 means LED commanded on.
REQ-005 fade_en  input  1  1 = trail (decay) mode; 0 = direct mode, no trail.
REQ-006 led_out  output  16  registered PWM-modulated LED drive; bit=1 lights the LED.
REQ-007 fading  output  1  registered; 1 while any LED has brightness in 1..14 and its led_q bit is 0.

Function
REQ-008 Input register: led_q[15:0] <= led_in every cycle; no other logic reads led_in directly.
REQ-009 Per-LED brightness lvl[i], 4 bits, range 0..15; 15 = full on, 0 = off.
REQ-010 Prescaler: 24-bit div_cnt counts 0..DECAY_DIV-1 and wraps to 0; decay_tick is 1 for exactly the cycle in which div_cnt == DECAY_DIV-1.
REQ-011 PWM counter: 4-bit pwm_cnt counts 0..14 and wraps to 0 (period 15 cycles); value 15 never occurs.
REQ-012 lvl[i] update priority, highest first: (a) led_q[i]==1 -> lvl[i] <= 15; (b) fade_en==0 -> lvl[i] <= 0; (c) decay_tick==1 and lvl[i]!=0 -> lvl[i] <= lvl[i]-1; (d) otherwise hold.
REQ-013 lvl[i] never underflows: at 0 with decay_tick it stays 0; no wrap to 15.
REQ-014 Re-assertion of led_q[i] during a fade reloads 15 on the next edge regardless of decay_tick in that cycle.
REQ-015 fade_en falling mid-fade clears all LEDs with led_q[i]==0 to lvl 0 on the next edge; fade_en rising does not restore lost levels.
REQ-016 led_out[i] <= (lvl[i] > pwm_cnt) every cycle; lvl 15 -> constantly 1, lvl 0 -> constantly 0, lvl k (1..14) -> exactly k high cycles per 15-cycle PWM period.
REQ-017 Latency: led_in bit rising at edge E0 (sampled) -> lvl=15 at E1 -> led_out bit 1 at E2, independent of pwm_cnt phase.
REQ-018 Latency: led_in bit falling with fade_en=0 -> led_out bit 0 at E2.
REQ-019 Decay duration: from the last cycle led_q[i]==1, lvl[i] reaches 0 after exactly 15 decay_ticks (15*DECAY_DIV cycles, ±DECAY_DIV for prescaler phase).
REQ-020 Prescaler and PWM counter run free and are never reset by led_in or fade_en activity.
REQ-021 fading <= OR over i of (led_q[i]==0 and lvl[i]!=0 and lvl[i]!=15), registered one cycle after lvl.
REQ-022 All 16 channels are identical and independent; simultaneous events on different bits do not interact.

Reset
REQ-023 While resetn==0: led_q=0, lvl[all]=0, div_cnt=0, pwm_cnt=0, led_out=16'h0000, fading=0.
REQ-024 Reset asserted mid-fade aborts the fade; after release, LEDs relight only from led_q per REQ-012.
REQ-025 First decay_tick after reset release occurs in cycle DECAY_DIV (counting release edge as cycle 1).

Verification (DECAY_DIV=4 in bench)
REQ-026 Reset, then led_in=16'h0001, fade_en=1 -> led_out[0]=1 from second edge on, steady; led_out[15:1]=0; fading=0.
REQ-027 From REQ-026 state, led_in=16'h0000 -> lvl[0] steps 15,14,..,0 once per 4 cycles; led_out[0] high count per 15-cycle window decreases monotonically to 0; fading 1 during, 0 after lvl[0]=0.
REQ-028 led_in rotating 16'hfffe left one bit every 8 cycles with fade_en=1 -> dark bit's lvl restores 15 two edges after re-set; no underflow/wrap observed on any channel.
REQ-029 Mid-fade (lvl[3]=9) drive fade_en=0 -> lvl[3]=0 and led_out[3]=0 within two edges; fading drops to 0.
REQ-030 Mid-fade with lvl[5]=7, pulse led_in[5]=1 for one cycle coinciding with decay_tick -> lvl[5]=15, not 14.
REQ-031 Assert resetn=0 asynchronously between edges during a fade -> led_out=16'h0000 immediately, before next clk edge; all counters 0.
